// File: rtl/sign_sync_pkg.sv
// sign_sync_pkg: edge mode encodings and counter width helper shared by the sign_sync area.
package sign_sync_pkg;
  localparam logic [1:0] EDGE_OFF  = 2'b00;
  localparam logic [1:0] EDGE_RISE = 2'b01;
  localparam logic [1:0] EDGE_FALL = 2'b10;
  localparam logic [1:0] EDGE_BOTH = 2'b11;
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/edge_filter_ch.sv
// edge_filter_ch: one channel of synchroniser, debounce filter, edge pulses and sticky flag.
module edge_filter_ch
  import sign_sync_pkg::*;
#(
  parameter int   SYNC_STAGES = 3,
  parameter int   FILT_CNT    = 8,
  parameter logic INIT_LEVEL  = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sign,
  input  logic [1:0] mode,
  input  logic       flag_clr,
  output logic       level,
  output logic       rising_edge,
  output logic       falling_edge,
  output logic       edge_flag
);
  localparam int CW = cnt_w(FILT_CNT);
  localparam logic [CW-1:0] CNT_MAX = CW'(FILT_CNT - 1);
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic level_q, level_d, rise_q, rise_d, fall_q, fall_d, flag_q, flag_d;
  logic s, match, fire, set;
  always_comb begin
    s = sync_q[SYNC_STAGES-1];
    match = s == level_q;
    fire = !match && cnt_q == CNT_MAX;
    sync_d = {sync_q[SYNC_STAGES-2:0], sign};
    cnt_d = (match || fire) ? '0 : cnt_q + 1'b1;
    level_d = fire ? s : level_q;
    rise_d = fire & s;
    fall_d = fire & ~s;
    set = (rise_q & mode[0]) | (fall_q & mode[1]);
    flag_d = set ? 1'b1 : (flag_clr ? 1'b0 : flag_q);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= {SYNC_STAGES{INIT_LEVEL}};
      cnt_q   <= '0;
      level_q <= INIT_LEVEL;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      flag_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      flag_q  <= flag_d;
    end
  end
  assign level        = level_q;
  assign rising_edge  = rise_q;
  assign falling_edge = fall_q;
  assign edge_flag    = flag_q;
endmodule

// File: rtl/multi_edge_filter.sv
// multi_edge_filter: CH independent filtered edge detectors with an OR-reduced interrupt.
module multi_edge_filter
  import sign_sync_pkg::*;
#(
  parameter int   CH          = 4,
  parameter int   SYNC_STAGES = 3,
  parameter int   FILT_CNT    = 8,
  parameter logic INIT_LEVEL  = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [CH-1:0] sign,
  input  logic [2*CH-1:0] edge_mode,
  input  logic [CH-1:0] flag_clr,
  output logic [CH-1:0] level,
  output logic [CH-1:0] rising_edge,
  output logic [CH-1:0] falling_edge,
  output logic [CH-1:0] edge_flag,
  output logic          irq
);
  for (genvar i = 0; i < CH; i++) begin : g_ch
    edge_filter_ch #(
      .SYNC_STAGES(SYNC_STAGES),
      .FILT_CNT   (FILT_CNT),
      .INIT_LEVEL (INIT_LEVEL)
    ) u_ch (
      .clk         (clk),
      .rst         (rst),
      .sign        (sign[i]),
      .mode        (edge_mode[2*i+:2]),
      .flag_clr    (flag_clr[i]),
      .level       (level[i]),
      .rising_edge (rising_edge[i]),
      .falling_edge(falling_edge[i]),
      .edge_flag   (edge_flag[i])
    );
  end
  assign irq = |edge_flag;
endmodule

// File: tb/tb_multi_edge_filter.sv
// tb_multi_edge_filter: randomized and directed stimulus checked by a queue scoreboard against a sample-history model.
module tb_multi_edge_filter;
  import sign_sync_pkg::*;
  localparam int CH = 4;
  localparam int SS = 3;
  localparam int FC = 8;
  localparam logic INIT = 1'b0;
  localparam int HL = SS + FC;
  typedef struct packed {
    logic [CH-1:0] level;
    logic [CH-1:0] rise;
    logic [CH-1:0] fall;
    logic [CH-1:0] flag;
    logic          irq;
  } exp_t;
  logic clk = 1'b0;
  logic rst;
  logic [CH-1:0] sign, flag_clr, level, rising_edge, falling_edge, edge_flag;
  logic [2*CH-1:0] edge_mode;
  logic irq;
  exp_t q[$];
  int vectors = 0;
  int miscompares = 0;
  logic hist [CH][HL];
  logic [CH-1:0] m_level, m_rise, m_fall, m_flag;
  multi_edge_filter #(.CH(CH), .SYNC_STAGES(SS), .FILT_CNT(FC), .INIT_LEVEL(INIT)) dut (
    .clk(clk), .rst(rst), .sign(sign), .edge_mode(edge_mode), .flag_clr(flag_clr),
    .level(level), .rising_edge(rising_edge), .falling_edge(falling_edge),
    .edge_flag(edge_flag), .irq(irq)
  );
  always #5 clk = ~clk;
  // The filtered level flips once FC consecutive synchronised samples all disagree with it;
  // sample hist[c][l] is the raw input taken l edges ago, so the filter sees lags SS..SS+FC-1.
  task automatic model(input logic r, input logic [CH-1:0] sg, input logic [2*CH-1:0] md,
                       input logic [CH-1:0] clr);
    exp_t e;
    for (int c = 0; c < CH; c++) begin
      if (r) begin
        for (int l = 0; l < HL; l++) hist[c][l] = INIT;
        m_level[c] = INIT; m_rise[c] = 0; m_fall[c] = 0; m_flag[c] = 0;
      end else begin
        bit set, flip;
        set = (m_rise[c] && md[2*c]) || (m_fall[c] && md[2*c+1]);
        m_flag[c] = set ? 1'b1 : (clr[c] ? 1'b0 : m_flag[c]);
        for (int l = HL - 1; l > 0; l--) hist[c][l] = hist[c][l-1];
        hist[c][0] = sg[c];
        flip = 1;
        for (int l = SS; l < HL; l++) if (hist[c][l] == m_level[c]) flip = 0;
        m_rise[c] = flip && !m_level[c];
        m_fall[c] = flip && m_level[c];
        if (flip) m_level[c] = !m_level[c];
      end
    end
    e.level = m_level; e.rise = m_rise; e.fall = m_fall; e.flag = m_flag; e.irq = |m_flag;
    q.push_back(e);
  endtask
  task automatic step(input logic r, input logic [CH-1:0] sg, input logic [2*CH-1:0] md,
                      input logic [CH-1:0] clr);
    rst = r; sign = sg; edge_mode = md; flag_clr = clr;
    @(posedge clk);
    model(r, sg, md, clr);
    #1;
  endtask
  task automatic hold(input int n, input logic r, input logic [CH-1:0] sg,
                      input logic [2*CH-1:0] md, input logic [CH-1:0] clr);
    for (int i = 0; i < n; i++) step(r, sg, md, clr);
  endtask
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      vectors++;
      if (level !== e.level) begin
        miscompares++;
        $display("FAIL level @%0t got %b want %b", $time, level, e.level);
      end
      if (rising_edge !== e.rise) begin
        miscompares++;
        $display("FAIL rising_edge @%0t got %b want %b", $time, rising_edge, e.rise);
      end
      if (falling_edge !== e.fall) begin
        miscompares++;
        $display("FAIL falling_edge @%0t got %b want %b", $time, falling_edge, e.fall);
      end
      if (edge_flag !== e.flag) begin
        miscompares++;
        $display("FAIL edge_flag @%0t got %b want %b", $time, edge_flag, e.flag);
      end
      if (irq !== e.irq) begin
        miscompares++;
        $display("FAIL irq @%0t got %b want %b", $time, irq, e.irq);
      end
      if ((rising_edge & falling_edge) != '0) begin
        miscompares++;
        $display("FAIL both_pulses @%0t got %b want 0", $time, rising_edge & falling_edge);
      end
    end
  end
  initial begin
    logic [CH-1:0] sg, clr;
    logic [2*CH-1:0] md;
    md = {EDGE_BOTH, EDGE_FALL, EDGE_BOTH, EDGE_RISE};
    hold(3, 1'b1, '0, md, '0);
    hold(20, 1'b0, '0, md, '0);
    hold(16, 1'b0, 4'b0001, md, '0);
    hold(7, 1'b0, 4'b0011, md, '0);
    hold(16, 1'b0, 4'b0001, md, '0);
    hold(8, 1'b0, 4'b0011, md, '0);
    hold(24, 1'b0, 4'b0001, md, '0);
    hold(16, 1'b0, 4'b0101, md, '0);
    hold(16, 1'b0, 4'b0001, md, '0);
    hold(14, 1'b0, 4'b1001, md, '0);
    hold(3, 1'b0, 4'b1001, md, 4'b1000);
    hold(16, 1'b0, 4'b1001, md, 4'b0111);
    hold(14, 1'b0, 4'b0001, md, '0);
    hold(3, 1'b1, 4'b0001, md, 4'b1111);
    hold(20, 1'b0, 4'b0001, md, '0);
    hold(3, 1'b0, 4'b1111, md, '0);
    hold(1, 1'b1, 4'b1111, md, '0);
    hold(16, 1'b0, 4'b1111, md, '0);
    sg = '0;
    for (int n = 0; n < 4000; n++) begin
      for (int c = 0; c < CH; c++) if ($urandom_range(0, 9) == 0) sg[c] = ~sg[c];
      if ($urandom_range(0, 49) == 0) md = 8'($urandom);
      for (int c = 0; c < CH; c++) clr[c] = ($urandom_range(0, 7) == 0);
      step($urandom_range(0, 299) == 0, sg, md, clr);
    end
    repeat (3) @(negedge clk);
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain got %0d pending want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
